// File: rtl/multicycle_sequencer.sv
// Control FSM of the multi-cycle core: IDLE, FETCH, DECODE, EXEC, MEM, WB and HALT.
// Define MCSEQ_PERF_CNT_EN to add the o_cycle_cnt / o_instret_cnt performance counters.
module multicycle_sequencer (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [1:0]  i_dec_aluop1_type,
  input  logic [1:0]  i_dec_aluop2_type,
  input  logic        i_dec_is_load,
  input  logic        i_dec_is_store,
  input  logic        i_dec_is_branch,
  input  logic        i_dec_is_jal,
  input  logic        i_dec_is_jalr,
  input  logic        i_dec_reg_we,
  input  logic        i_dec_illegal,
  input  logic        i_br_taken,
  input  logic        i_imem_ready,
  input  logic        i_dmem_ready,
  output logic [1:0]  o_aluop1_type,
  output logic [1:0]  o_aluop2_type,
  output logic        o_imm_four,
  output logic        o_alu_force_add,
  output logic        o_imem_req,
  output logic        o_dmem_req,
  output logic        o_dmem_we,
  output logic        o_ir_we,
  output logic        o_npc_we,
  output logic        o_tgt_we,
  output logic        o_alu_out_we,
  output logic        o_reg_we,
  output logic        o_pc_we,
  output logic [1:0]  o_pc_sel,
  output logic [1:0]  o_wb_sel,
  output logic        o_halted,
`ifdef MCSEQ_PERF_CNT_EN
  output logic [31:0] o_cycle_cnt,
  output logic [31:0] o_instret_cnt,
`endif
  output logic [2:0]  o_state
);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StFetch  = 3'd1,
    StDecode = 3'd2,
    StExec   = 3'd3,
    StMem    = 3'd4,
    StWb     = 3'd5,
    StHalt   = 3'd6
  } state_e;

  state_e r_state;
  state_e w_state_d;

  // Class flags with priority applied: branch > load > store > jal > jalr.
  logic w_br, w_ld, w_st, w_jal, w_jalr;
  assign w_br   = i_dec_is_branch;
  assign w_ld   = i_dec_is_load  & ~w_br;
  assign w_st   = i_dec_is_store & ~w_br & ~i_dec_is_load;
  assign w_jal  = i_dec_is_jal   & ~w_br & ~i_dec_is_load & ~i_dec_is_store;
  assign w_jalr = i_dec_is_jalr  & ~w_br & ~i_dec_is_load & ~i_dec_is_store & ~i_dec_is_jal;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= StIdle;
    else       r_state <= w_state_d;
  end

  always_comb begin
    w_state_d = StIdle;
    case (r_state)
      StIdle:   w_state_d = StFetch;
      StFetch:  w_state_d = i_imem_ready ? StDecode : StFetch;
      StDecode: w_state_d = i_dec_illegal ? StHalt : StExec;
      StExec: begin
        if (w_br)             w_state_d = StFetch;
        else if (w_ld | w_st) w_state_d = StMem;
        else                  w_state_d = StWb;
      end
      StMem: begin
        if (!i_dmem_ready) w_state_d = StMem;
        else if (w_ld)     w_state_d = StWb;
        else               w_state_d = StFetch;
      end
      StWb:     w_state_d = StFetch;
      StHalt:   w_state_d = StHalt;
      default:  w_state_d = StIdle;
    endcase
  end

  always_comb begin
    o_aluop1_type   = 2'b11;
    o_aluop2_type   = 2'b11;
    o_imm_four      = 1'b0;
    o_alu_force_add = 1'b0;
    o_imem_req      = 1'b0;
    o_dmem_req      = 1'b0;
    o_dmem_we       = 1'b0;
    o_ir_we         = 1'b0;
    o_npc_we        = 1'b0;
    o_tgt_we        = 1'b0;
    o_alu_out_we    = 1'b0;
    o_reg_we        = 1'b0;
    o_pc_we         = 1'b0;
    o_pc_sel        = 2'b00;
    o_wb_sel        = 2'b00;
    o_halted        = 1'b0;
    case (r_state)
      StFetch: begin
        // ALU computes PC + 4 while the fetch is outstanding.
        o_imem_req      = 1'b1;
        o_aluop1_type   = 2'b10;
        o_aluop2_type   = 2'b01;
        o_imm_four      = 1'b1;
        o_alu_force_add = 1'b1;
        o_ir_we         = i_imem_ready;
        o_npc_we        = i_imem_ready;
      end
      StDecode: begin
        // ALU computes PC + imm as the speculative branch/jump target.
        o_aluop1_type   = 2'b10;
        o_aluop2_type   = 2'b01;
        o_alu_force_add = 1'b1;
        o_tgt_we        = 1'b1;
      end
      StExec: begin
        o_aluop1_type = i_dec_aluop1_type;
        o_aluop2_type = i_dec_aluop2_type;
        o_alu_out_we  = 1'b1;
        if (w_br) begin
          o_pc_we  = 1'b1;
          o_pc_sel = i_br_taken ? 2'b01 : 2'b00;
        end
      end
      StMem: begin
        o_dmem_req = 1'b1;
        o_dmem_we  = w_st;
        if (i_dmem_ready && !w_ld) o_pc_we = 1'b1;
      end
      StWb: begin
        o_reg_we = i_dec_reg_we;
        o_pc_we  = 1'b1;
        if (w_ld)               o_wb_sel = 2'b01;
        else if (w_jal | w_jalr) o_wb_sel = 2'b10;
        if (w_jal)       o_pc_sel = 2'b01;
        else if (w_jalr) o_pc_sel = 2'b10;
      end
      StHalt:  o_halted = 1'b1;
      default: ;
    endcase
  end

  assign o_state = r_state;

`ifdef MCSEQ_PERF_CNT_EN
  logic [31:0] r_cycle_cnt;
  logic [31:0] r_instret_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cycle_cnt   <= 32'd0;
      r_instret_cnt <= 32'd0;
    end else begin
      if (r_state != StIdle && r_state != StHalt) r_cycle_cnt <= r_cycle_cnt + 32'd1;
      if (o_pc_we) r_instret_cnt <= r_instret_cnt + 32'd1;
    end
  end

  assign o_cycle_cnt   = r_cycle_cnt;
  assign o_instret_cnt = r_instret_cnt;
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer: every output is packed into one vector and
// compared against hand-written expectations each cycle.
module tb_multicycle_sequencer;

  logic       i_clk, i_rst;
  logic [1:0] i_dec_aluop1_type, i_dec_aluop2_type;
  logic       i_dec_is_load, i_dec_is_store, i_dec_is_branch, i_dec_is_jal, i_dec_is_jalr;
  logic       i_dec_reg_we, i_dec_illegal, i_br_taken, i_imem_ready, i_dmem_ready;
  logic [1:0] o_aluop1_type, o_aluop2_type, o_pc_sel, o_wb_sel;
  logic       o_imm_four, o_alu_force_add, o_imem_req, o_dmem_req, o_dmem_we;
  logic       o_ir_we, o_npc_we, o_tgt_we, o_alu_out_we, o_reg_we, o_pc_we, o_halted;
  logic [2:0] o_state;
`ifdef MCSEQ_PERF_CNT_EN
  logic [31:0] o_cycle_cnt, o_instret_cnt;
`endif

  multicycle_sequencer u_dut (
    .i_clk             (i_clk),
    .i_rst             (i_rst),
    .i_dec_aluop1_type (i_dec_aluop1_type),
    .i_dec_aluop2_type (i_dec_aluop2_type),
    .i_dec_is_load     (i_dec_is_load),
    .i_dec_is_store    (i_dec_is_store),
    .i_dec_is_branch   (i_dec_is_branch),
    .i_dec_is_jal      (i_dec_is_jal),
    .i_dec_is_jalr     (i_dec_is_jalr),
    .i_dec_reg_we      (i_dec_reg_we),
    .i_dec_illegal     (i_dec_illegal),
    .i_br_taken        (i_br_taken),
    .i_imem_ready      (i_imem_ready),
    .i_dmem_ready      (i_dmem_ready),
    .o_aluop1_type     (o_aluop1_type),
    .o_aluop2_type     (o_aluop2_type),
    .o_imm_four        (o_imm_four),
    .o_alu_force_add   (o_alu_force_add),
    .o_imem_req        (o_imem_req),
    .o_dmem_req        (o_dmem_req),
    .o_dmem_we         (o_dmem_we),
    .o_ir_we           (o_ir_we),
    .o_npc_we          (o_npc_we),
    .o_tgt_we          (o_tgt_we),
    .o_alu_out_we      (o_alu_out_we),
    .o_reg_we          (o_reg_we),
    .o_pc_we           (o_pc_we),
    .o_pc_sel          (o_pc_sel),
    .o_wb_sel          (o_wb_sel),
    .o_halted          (o_halted),
`ifdef MCSEQ_PERF_CNT_EN
    .o_cycle_cnt       (o_cycle_cnt),
    .o_instret_cnt     (o_instret_cnt),
`endif
    .o_state           (o_state)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Strobe order: imm_four force_add imem_req dmem_req dmem_we ir_we npc_we tgt_we
  //               alu_out_we reg_we pc_we halted
  localparam logic [11:0] S_NONE     = 12'b0000_0000_0000;
  localparam logic [11:0] S_FETCH_W  = 12'b1110_0000_0000;
  localparam logic [11:0] S_FETCH_R  = 12'b1110_0110_0000;
  localparam logic [11:0] S_DEC      = 12'b0100_0001_0000;
  localparam logic [11:0] S_EXEC     = 12'b0000_0000_1000;
  localparam logic [11:0] S_EXEC_BR  = 12'b0000_0000_1010;
  localparam logic [11:0] S_MEM_LD   = 12'b0001_0000_0000;
  localparam logic [11:0] S_MEM_ST   = 12'b0001_1000_0000;
  localparam logic [11:0] S_MEM_ST_R = 12'b0001_1000_0010;
  localparam logic [11:0] S_WB       = 12'b0000_0000_0110;
  localparam logic [11:0] S_HALT     = 12'b0000_0000_0001;

  logic [22:0] w_obs;
  assign w_obs = {o_state, o_aluop1_type, o_aluop2_type,
                  o_imm_four, o_alu_force_add, o_imem_req, o_dmem_req, o_dmem_we, o_ir_we,
                  o_npc_we, o_tgt_we, o_alu_out_we, o_reg_we, o_pc_we, o_halted,
                  o_pc_sel, o_wb_sel};

  int n_cmp = 0;
  int n_err = 0;

  function automatic logic [22:0] ev(input logic [2:0] st, input logic [1:0] o1,
                                     input logic [1:0] o2, input logic [11:0] s,
                                     input logic [1:0] ps, input logic [1:0] ws);
    return {st, o1, o2, s, ps, ws};
  endfunction

  task automatic chk(input string tag, input logic [22:0] exp);
    n_cmp++;
    assert (w_obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, w_obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic set_dec(input logic [1:0] op1, input logic [1:0] op2, input logic ld,
                         input logic st, input logic br, input logic jal, input logic jalr,
                         input logic rwe, input logic ill);
    i_dec_aluop1_type = op1;
    i_dec_aluop2_type = op2;
    i_dec_is_load     = ld;
    i_dec_is_store    = st;
    i_dec_is_branch   = br;
    i_dec_is_jal      = jal;
    i_dec_is_jalr     = jalr;
    i_dec_reg_we      = rwe;
    i_dec_illegal     = ill;
  endtask

  initial begin
    i_rst = 1'b1;
    set_dec(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    i_br_taken   = 1'b0;
    i_imem_ready = 1'b1;
    i_dmem_ready = 1'b0;

    // Reset
    #3 chk("reset_async", ev(3'd0, 2'b11, 2'b11, S_NONE, 2'b00, 2'b00));
    tick();
    chk("reset_held", ev(3'd0, 2'b11, 2'b11, S_NONE, 2'b00, 2'b00));
    i_rst = 1'b0;
    #1 chk("idle_after_rst", ev(3'd0, 2'b11, 2'b11, S_NONE, 2'b00, 2'b00));

    // R-type ADD: 1,2,3,5,1
    set_dec(2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 0);
    tick(); chk("add_fetch", ev(3'd1, 2'b10, 2'b01, S_FETCH_R, 2'b00, 2'b00));
    tick(); chk("add_decode", ev(3'd2, 2'b10, 2'b01, S_DEC, 2'b00, 2'b00));
    tick(); chk("add_exec", ev(3'd3, 2'b00, 2'b00, S_EXEC, 2'b00, 2'b00));
    tick(); chk("add_wb", ev(3'd5, 2'b11, 2'b11, S_WB, 2'b00, 2'b00));
    tick(); chk("add_refetch", ev(3'd1, 2'b10, 2'b01, S_FETCH_R, 2'b00, 2'b00));

    // Taken branch: EXEC redirects to TGT, no MEM/WB
    set_dec(2'b00, 2'b00, 0, 0, 1, 0, 0, 0, 0);
    i_br_taken = 1'b1;
    tick(); chk("br_decode", ev(3'd2, 2'b10, 2'b01, S_DEC, 2'b00, 2'b00));
    tick(); chk("br_exec", ev(3'd3, 2'b00, 2'b00, S_EXEC_BR, 2'b01, 2'b00));
    tick(); chk("br_refetch", ev(3'd1, 2'b10, 2'b01, S_FETCH_R, 2'b00, 2'b00));

    // Not-taken branch with load flag also set: branch has priority
    set_dec(2'b00, 2'b00, 1, 0, 1, 0, 0, 1, 0);
    i_br_taken = 1'b0;
    tick(); chk("brnt_decode", ev(3'd2, 2'b10, 2'b01, S_DEC, 2'b00, 2'b00));
    tick(); chk("brnt_exec", ev(3'd3, 2'b00, 2'b00, S_EXEC_BR, 2'b00, 2'b00));
    tick(); chk("brnt_refetch", ev(3'd1, 2'b10, 2'b01, S_FETCH_R, 2'b00, 2'b00));

    // Load, dmem_ready low 3 cycles
    set_dec(2'b00, 2'b01, 1, 0, 0, 0, 0, 1, 0);
    tick(); chk("ld_decode", ev(3'd2, 2'b10, 2'b01, S_DEC, 2'b00, 2'b00));
    tick(); chk("ld_exec", ev(3'd3, 2'b00, 2'b01, S_EXEC, 2'b00, 2'b00));
    for (int i = 0; i < 3; i++) begin
      tick(); chk("ld_mem_wait", ev(3'd4, 2'b11, 2'b11, S_MEM_LD, 2'b00, 2'b00));
    end
    i_dmem_ready = 1'b1;
    #1 chk("ld_mem_ready", ev(3'd4, 2'b11, 2'b11, S_MEM_LD, 2'b00, 2'b00));
    tick(); chk("ld_wb", ev(3'd5, 2'b11, 2'b11, S_WB, 2'b00, 2'b01));
    tick(); chk("ld_refetch", ev(3'd1, 2'b10, 2'b01, S_FETCH_R, 2'b00, 2'b00));

    // imem_ready low 2 cycles; stray dmem_ready must be ignored. Instruction: jal
    set_dec(2'b10, 2'b01, 0, 0, 0, 1, 0, 1, 0);
    i_imem_ready = 1'b0;
    #1 chk("fetch_wait0", ev(3'd1, 2'b10, 2'b01, S_FETCH_W, 2'b00, 2'b00));
    tick(); chk("fetch_wait1", ev(3'd1, 2'b10, 2'b01, S_FETCH_W, 2'b00, 2'b00));
    tick(); chk("fetch_wait2", ev(3'd1, 2'b10, 2'b01, S_FETCH_W, 2'b00, 2'b00));
    i_imem_ready = 1'b1;
    i_dmem_ready = 1'b0;
    #1 chk("fetch_ready", ev(3'd1, 2'b10, 2'b01, S_FETCH_R, 2'b00, 2'b00));
    tick(); chk("jal_decode", ev(3'd2, 2'b10, 2'b01, S_DEC, 2'b00, 2'b00));
    tick(); chk("jal_exec", ev(3'd3, 2'b10, 2'b01, S_EXEC, 2'b00, 2'b00));
    tick(); chk("jal_wb", ev(3'd5, 2'b11, 2'b11, S_WB, 2'b01, 2'b10));
    tick(); chk("jal_refetch", ev(3'd1, 2'b10, 2'b01, S_FETCH_R, 2'b00, 2'b00));

    // Store (jal flag also set; store wins), zero-wait memory
    set_dec(2'b00, 2'b01, 0, 1, 0, 1, 0, 0, 0);
    i_dmem_ready = 1'b1;
    tick(); chk("st_decode", ev(3'd2, 2'b10, 2'b01, S_DEC, 2'b00, 2'b00));
    tick(); chk("st_exec", ev(3'd3, 2'b00, 2'b01, S_EXEC, 2'b00, 2'b00));
    tick(); chk("st_mem", ev(3'd4, 2'b11, 2'b11, S_MEM_ST_R, 2'b00, 2'b00));
    tick(); chk("st_refetch", ev(3'd1, 2'b10, 2'b01, S_FETCH_R, 2'b00, 2'b00));

    // jalr
    set_dec(2'b00, 2'b01, 0, 0, 0, 0, 1, 1, 0);
    i_dmem_ready = 1'b0;
    tick(); chk("jalr_decode", ev(3'd2, 2'b10, 2'b01, S_DEC, 2'b00, 2'b00));
    tick(); chk("jalr_exec", ev(3'd3, 2'b00, 2'b01, S_EXEC, 2'b00, 2'b00));
    tick(); chk("jalr_wb", ev(3'd5, 2'b11, 2'b11, S_WB, 2'b10, 2'b10));
    tick(); chk("jalr_refetch", ev(3'd1, 2'b10, 2'b01, S_FETCH_R, 2'b00, 2'b00));

    // Illegal: HALT, sticky for 20 cycles despite ready inputs
    set_dec(2'b00, 2'b00, 1, 0, 0, 0, 0, 1, 1);
    i_dmem_ready = 1'b1;
    tick(); chk("ill_decode", ev(3'd2, 2'b10, 2'b01, S_DEC, 2'b00, 2'b00));
    for (int i = 0; i < 20; i++) begin
      tick(); chk("halt_sticky", ev(3'd6, 2'b11, 2'b11, S_HALT, 2'b00, 2'b00));
    end
    #2 i_rst = 1'b1;
    #1 chk("halt_rst", ev(3'd0, 2'b11, 2'b11, S_NONE, 2'b00, 2'b00));
    #2 i_rst = 1'b0;

    // Asynchronous reset in the middle of a MEM wait
    set_dec(2'b00, 2'b01, 1, 0, 0, 0, 0, 1, 0);
    i_dmem_ready = 1'b0;
    tick(); chk("rst2_fetch", ev(3'd1, 2'b10, 2'b01, S_FETCH_R, 2'b00, 2'b00));
    tick(); tick(); tick();
    chk("rst2_mem", ev(3'd4, 2'b11, 2'b11, S_MEM_LD, 2'b00, 2'b00));
    #2 i_rst = 1'b1;
    #1 chk("rst2_async", ev(3'd0, 2'b11, 2'b11, S_NONE, 2'b00, 2'b00));
`ifdef MCSEQ_PERF_CNT_EN
    n_cmp++;
    assert (o_cycle_cnt === 32'd0 && o_instret_cnt === 32'd0) else begin
      n_err++;
      $error("FAIL perf_rst: observed %h/%h expected 0/0", o_cycle_cnt, o_instret_cnt);
    end
`endif
    #2 i_rst = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
